// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-side FIFO controller with a 3-entry output buffer
// Optional accepted-beat counter rd_count_o is built in with FIFO_RD_CTRL_CNT_EN.
module fifo_rd_ctrl #(
  parameter int unsigned data_width = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  en_i,
  input  logic                  fifo_empty_i,
  input  logic [data_width-1:0] fifo_data_i,
  output logic                  fifo_cs_o,
  output logic                  fifo_rd_en_o,
  output logic                  m_valid_o,
  output logic [data_width-1:0] m_data_o,
  input  logic                  m_ready_i
`ifdef FIFO_RD_CTRL_CNT_EN
  ,
  output logic [31:0]           rd_count_o
`endif
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [data_width-1:0] buf_q [3];

  logic [2:0]            load;
  logic                  issue;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue only when the words already owed to the buffer leave room for one more,
  // so a stalled consumer can never cause a dropped capture.
  always_comb begin
    load  = {1'b0, occ_q} + {2'b00, inflight_q};
    issue = rstn_i && en_i && !fifo_empty_i && (load < 3'd3);
  end

  assign fifo_rd_en_o = issue;
  assign fifo_cs_o    = issue;

  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = buf_q[head_q];
  assign pop       = m_valid_o && m_ready_i;

  always_comb begin
    occ_d  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    head_d = pop ? ptr_inc(head_q) : head_q;
    tail_d = inflight_q ? ptr_inc(tail_q) : tail_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      occ_q      <= occ_d;
      inflight_q <= issue;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (inflight_q) begin
        buf_q[tail_q] <= fifo_data_i;
      end
    end
  end

`ifdef FIFO_RD_CTRL_CNT_EN
  logic [31:0] rd_count_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rd_count_q <= 32'd0;
    end else if (pop) begin
      rd_count_q <= rd_count_q + 32'd1;
    end
  end

  assign rd_count_o = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed self-checking bench for fifo_rd_ctrl
// Includes a behavioural FIFO with one-cycle read latency.
module tb_fifo_rd_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        fifo_empty;
  logic [31:0] fifo_data = 32'd0;
  logic        fifo_cs;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
`ifdef FIFO_RD_CTRL_CNT_EN
  logic [31:0] rd_count;
`endif

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.data_width(32)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .en_i         (en),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_cs_o    (fifo_cs),
    .fifo_rd_en_o (fifo_rd_en),
    .m_valid_o    (m_valid),
    .m_data_o     (m_data),
    .m_ready_i    (m_ready)
`ifdef FIFO_RD_CTRL_CNT_EN
    ,
    .rd_count_o   (rd_count)
`endif
  );

  // Behavioural FIFO: bench writes at negedge, reads complete at posedge.
  logic [31:0] mem [0:63];
  int wp = 0;
  int rp = 0;

  assign fifo_empty = (rp == wp);

  always @(posedge clk) begin
    if (fifo_rd_en && (rp != wp)) begin
      fifo_data <= mem[rp[5:0]];
      rp        <= rp + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  logic        rdh [0:31];
  logic        vh  [0:31];
  logic [31:0] dh  [0:31];
  logic [31:0] beats [0:31];
  int nrd, nbeat, first_beat, last_beat;

  task automatic push(input logic [31:0] w);
    mem[wp[5:0]] = w;
    wp = wp + 1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      rdh[c] = fifo_rd_en;
      vh[c]  = m_valid && m_ready;
      dh[c]  = m_data;
      step();
    end
  endtask

  task automatic analyze(input int n);
    nrd = 0;
    nbeat = 0;
    first_beat = -1;
    last_beat = -1;
    for (int c = 0; c < n; c++) begin
      if (rdh[c]) nrd++;
      if (vh[c]) begin
        beats[nbeat] = dh[c];
        nbeat++;
        if (first_beat < 0) first_beat = c;
        last_beat = c;
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(32'(i * 'h11));

    // Reset with the FIFO preloaded
    step();
    check("rst1_valid", {31'd0, m_valid}, 32'd0);
    check("rst1_data", m_data, 32'd0);
    check("rst1_rden", {31'd0, fifo_rd_en}, 32'd0);
    step();
    check("rst2_valid", {31'd0, m_valid}, 32'd0);
    check("rst2_data", m_data, 32'd0);
    check("rst2_rden", {31'd0, fifo_rd_en}, 32'd0);
    check("rst2_cs", {31'd0, fifo_cs}, 32'd0);
    rstn = 1'b1;
    #1;
    check("rel_rden", {31'd0, fifo_rd_en}, 32'd1);

    // Streaming 0x11..0x88
    capture(14);
    analyze(14);
    check("str_nrd", 32'(nrd), 32'd8);
    check("str_first", 32'(first_beat), 32'd2);
    check("str_last", 32'(last_beat), 32'd9);
    check("str_nbeat", 32'(nbeat), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("str_beat%0d", i), beats[i], 32'((i + 1) * 'h11));
`ifdef FIFO_RD_CTRL_CNT_EN
    check("cnt_8", rd_count, 32'd8);
`endif

    // Back-pressure
    m_ready = 1'b0;
    en = 1'b0;
    for (int i = 1; i <= 8; i++) push(32'h30 + 32'(i));
    en = 1'b1;
    #1;
    capture(10);
    analyze(10);
    check("bp_nrd", 32'(nrd), 32'd3);
    check("bp_rden_end", {31'd0, fifo_rd_en}, 32'd0);
    check("bp_valid", {31'd0, m_valid}, 32'd1);
    check("bp_head", m_data, 32'h31);
    begin
      int unstable = 0;
      for (int c = 4; c < 10; c++) if (dh[c] !== 32'h31) unstable++;
      check("bp_stable", 32'(unstable), 32'd0);
    end
    m_ready = 1'b1;
    #1;
    capture(12);
    analyze(12);
    check("bp_r0_rden", {31'd0, rdh[0]}, 32'd0);
    check("bp_r1_rden", {31'd0, rdh[1]}, 32'd1);
    check("bp_nbeat", 32'(nbeat), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("bp_beat%0d", i), beats[i], 32'h31 + 32'(i));
`ifdef FIFO_RD_CTRL_CNT_EN
    check("cnt_16", rd_count, 32'd16);
`endif

    // Single word at the empty boundary
    push(32'hA5);
    #1;
    capture(8);
    analyze(8);
    check("one_nrd", 32'(nrd), 32'd1);
    check("one_nbeat", 32'(nbeat), 32'd1);
    check("one_beat", beats[0], 32'hA5);
    check("one_valid_end", {31'd0, m_valid}, 32'd0);

    // en dropped the cycle after an issue
    en = 1'b0;
    for (int i = 1; i <= 4; i++) push(32'h50 + 32'(i));
    en = 1'b1;
    #1;
    check("en_issue", {31'd0, fifo_rd_en}, 32'd1);
    step();
    en = 1'b0;
    #1;
    capture(6);
    analyze(6);
    check("en_nrd", 32'(nrd), 32'd0);
    check("en_nbeat", 32'(nbeat), 32'd1);
    check("en_beat", beats[0], 32'h51);
    wp = rp;

    // Reset with occ=2, inflight=1
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(32'h60 + 32'(i));
    en = 1'b1;
    #1;
    capture(3);
    check("mid_valid", {31'd0, m_valid}, 32'd1);
    check("mid_rden", {31'd0, fifo_rd_en}, 32'd0);
    rstn = 1'b0;
    step();
    check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_data", m_data, 32'd0);
    check("mid_rst_rden", {31'd0, fifo_rd_en}, 32'd0);
`ifdef FIFO_RD_CTRL_CNT_EN
    check("cnt_rst", rd_count, 32'd0);
`endif
    wp = rp;
    rstn = 1'b1;
    m_ready = 1'b1;
    #1;
    capture(4);
    analyze(4);
    check("post_nrd", 32'(nrd), 32'd0);
    check("post_nbeat", 32'(nbeat), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
